// File: rtl/mnist_frame_feeder.sv
// mnist_frame_feeder
//   Front end of the handwriting recognizer. The block takes a 28x28 frame
//   of 8-bit pixels and thresholds each pixel into one bit of a frame buffer.
//   It then holds the recognizer in reset, streams the buffer to it serially,
//   one bit per clock, and hands the recognizer's digit to a downstream
//   consumer.
//
//   Optional feature macro: MNIST_FEEDER_TIMEOUT_EN. When it is defined, a
//   watchdog on the WAIT state ends a hung recognizer run with digit 4'hF and
//   res_err=1.
//
//   Ports
//     clk        block and recognizer clock
//     rst        asynchronous active-low reset
//     pix_data   pixel input, row-major order
//     pix_valid  pixel valid
//     pix_ready  high while a frame is being loaded
//     rec_rst    active-high reset to the recognizer
//     rec_data   serial frame bit to the recognizer
//     rec_busy   recognizer status; not used for control
//     rec_digit  recognizer result digit
//     rec_valid  recognizer result valid
//     res_digit  captured digit
//     res_valid  result available
//     res_ready  consumer accept
//     res_err    watchdog timeout flag (always 0 without the macro)
module mnist_frame_feeder #(
    parameter int          NPIX           = 784,
    parameter logic [7:0]  THRESHOLD      = 8'd128,
    parameter int          RST_CYCLES     = 2,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       rec_rst,
    output logic       rec_data,
    input  logic       rec_busy,
    input  logic [3:0] rec_digit,
    input  logic       rec_valid,
    output logic [3:0] res_digit,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_err
);

    typedef enum logic [2:0] {S_LOAD, S_RST, S_SEND, S_WAIT, S_OUT} state_t;

    localparam logic [9:0] LAST_PIX = 10'(NPIX - 1);
    localparam logic [9:0] NPIX_C   = 10'(NPIX);
    localparam logic [9:0] RST_LAST = 10'(RST_CYCLES - 1);

    state_t            state;
    logic [9:0]        cnt;
    logic [NPIX-1:0]   fbuf;

    // rec_busy is status only.
    logic unused;
    assign unused = rec_busy;

`ifdef MNIST_FEEDER_TIMEOUT_EN
    localparam logic [12:0] WD_LAST = 13'(TIMEOUT_CYCLES - 1);
    logic [12:0] wd;
`else
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_LOAD;
            cnt       <= '0;
            fbuf      <= '0;
            pix_ready <= 1'b1;
            rec_rst   <= 1'b1;
            rec_data  <= 1'b0;
            res_digit <= 4'd0;
            res_valid <= 1'b0;
`ifdef MNIST_FEEDER_TIMEOUT_EN
            wd        <= '0;
            res_err   <= 1'b0;
`endif
        end else begin
            case (state)
                S_LOAD: begin
                    if (pix_valid && pix_ready) begin
                        fbuf[cnt] <= (pix_data >= THRESHOLD);
                        if (cnt == LAST_PIX) begin
                            cnt       <= '0;
                            pix_ready <= 1'b0;
                            state     <= S_RST;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                end
                S_RST: begin
                    // rec_data is loaded with bit[0] on the same edge that
                    // drops rec_rst. The recognizer's first edge out of
                    // reset therefore samples bit[0].
                    if (cnt == RST_LAST) begin
                        rec_rst  <= 1'b0;
                        rec_data <= fbuf[0];
                        fbuf     <= fbuf >> 1;
                        cnt      <= 10'd1;
                        state    <= S_SEND;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                S_SEND: begin
                    // The buffer shifts out LSB first. Here cnt is the
                    // number of bits already driven.
                    if (cnt == NPIX_C) begin
                        rec_data <= 1'b0;
                        cnt      <= '0;
                        state    <= S_WAIT;
`ifdef MNIST_FEEDER_TIMEOUT_EN
                        wd       <= '0;
`endif
                    end else begin
                        rec_data <= fbuf[0];
                        fbuf     <= fbuf >> 1;
                        cnt      <= cnt + 10'd1;
                    end
                end
                S_WAIT: begin
                    if (rec_valid) begin
                        res_digit <= rec_digit;
                        res_valid <= 1'b1;
                        state     <= S_OUT;
                    end
`ifdef MNIST_FEEDER_TIMEOUT_EN
                    else if (wd == WD_LAST) begin
                        res_digit <= 4'hF;
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        wd <= wd + 13'd1;
                    end
`endif
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        rec_rst   <= 1'b1;
                        pix_ready <= 1'b1;
                        cnt       <= '0;
                        state     <= S_LOAD;
`ifdef MNIST_FEEDER_TIMEOUT_EN
                        res_err   <= 1'b0;
`endif
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mnist_frame_feeder.sv
module tb_mnist_frame_feeder;

    localparam int NPIX = 784;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       rec_rst;
    logic       rec_data;
    logic       rec_busy;
    logic [3:0] rec_digit;
    logic       rec_valid;
    logic [3:0] res_digit;
    logic       res_valid;
    logic       res_ready;
    logic       res_err;

    int n_chk  = 0;
    int n_fail = 0;

    mnist_frame_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .rec_rst   (rec_rst),
        .rec_data  (rec_data),
        .rec_busy  (rec_busy),
        .rec_digit (rec_digit),
        .rec_valid (rec_valid),
        .res_digit (res_digit),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pixel patterns: 0 alternating 200/10, 1 threshold boundary, 2 every third pixel set
    function automatic logic [7:0] pix_of(input int mode, input int i);
        case (mode)
            0:       return (i % 2 == 0) ? 8'd200 : 8'd10;
            1:       return (i == 0) ? 8'd127 : (i == 1) ? 8'd128 : 8'd0;
            default: return (i % 3 == 0) ? 8'd128 : 8'd127;
        endcase
    endfunction

    function automatic logic bit_of(input int mode, input int i);
        case (mode)
            0:       return (i % 2 == 0);
            1:       return (i == 1);
            default: return (i % 3 == 0);
        endcase
    endfunction

    task automatic send_frame(input int mode, input int npx, input int gap_pct);
        int nrdy = 0;
        for (int i = 0; i < npx; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                pix_valid = 1'b0;
                pix_data  = 8'($urandom);
                step();
            end
            pix_data  = pix_of(mode, i);
            pix_valid = 1'b1;
            if (!pix_ready) nrdy++;
            step();
        end
        chk("load_ready_low_cnt", nrdy, 0);
    endtask

    // Called right after the last pixel handshake. pix_valid stays high
    // with garbage data so that any acceptance outside LOAD is exposed.
    task automatic stream_check(input int mode);
        int rh = 0, nerr = 0, first = -1, nrdy = 0;
        pix_data  = 8'hFF;
        pix_valid = 1'b1;
        chk("ready_after_frame", pix_ready, 0);
        while (rec_rst && rh < 20) begin
            rh++;
            if (pix_ready) nrdy++;
            step();
        end
        chk("rec_rst_cycles", rh, 2);
        for (int k = 0; k < NPIX; k++) begin
            if (rec_data !== bit_of(mode, k) || rec_rst !== 1'b0) begin
                nerr++;
                if (first < 0) first = k;
            end
            if (pix_ready) nrdy++;
            step();
        end
        chk("stream_bit_errs", nerr, 0);
        chk("stream_first_err", first, 32'hFFFF_FFFF);
        chk("rec_data_after", rec_data, 0);
        chk("ready_in_rst_send", nrdy, 0);
    endtask

    // Recognizer model: result after dly cycles; consumer holds off hold cycles.
    task automatic finish_result(input logic [3:0] d, input int dly, input int hold);
        int bad = 0, ok = 0;
        for (int i = 0; i < dly; i++) begin
            if (res_valid || pix_ready || rec_rst) bad++;
            step();
        end
        chk("wait_quiet", bad, 0);
        rec_digit = d;
        rec_valid = 1'b1;
        step();
        rec_valid = 1'b0;
        rec_digit = 4'd0;
        pix_valid = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            if (res_valid === 1'b1 && res_digit === d && res_err === 1'b0 && pix_ready === 1'b0) ok++;
            if (i == hold) res_ready = 1'b1;
            step();
        end
        res_ready = 1'b0;
        chk("res_stable_cycles", ok, hold + 1);
        chk("res_valid_cleared", res_valid, 0);
        chk("ready_back", pix_ready, 1);
        chk("rec_rst_back", rec_rst, 1);
    endtask

    initial begin
        rst = 1'b0; pix_data = '0; pix_valid = 1'b0; rec_busy = 1'b0;
        rec_digit = '0; rec_valid = 1'b0; res_ready = 1'b0;
        #12;
        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_rec_rst", rec_rst, 1);
        chk("rst_rec_data", rec_data, 0);
        chk("rst_res", {res_valid, res_err, res_digit}, 0);
        step();
        rst = 1'b1;
        step();

        // 1: alternating frame with valid held high, result digit 7 after 100 cycles
        send_frame(0, NPIX, 0);
        stream_check(0);
        finish_result(4'd7, 100, 20);

        // 2: threshold boundary, out-of-range digit passes through
        send_frame(1, NPIX, 0);
        stream_check(1);
        finish_result(4'hC, 5, 0);

        // 3: same alternating frame with 30% idle gaps
        send_frame(0, NPIX, 30);
        stream_check(0);
        finish_result(4'd3, 1, 2);

        // 5: reset in the middle of a frame, then a fresh frame
        send_frame(0, 400, 0);
        pix_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", pix_ready, 1);
        chk("mid_rst_rec_rst", rec_rst, 1);
        step();
        rst = 1'b1;
        step();
        send_frame(2, NPIX, 0);
        stream_check(2);
        finish_result(4'd9, 3, 1);

`ifdef MNIST_FEEDER_TIMEOUT_EN
        // 6: recognizer never answers
        begin
            int early = 0;
            send_frame(0, NPIX, 0);
            stream_check(0);
            pix_valid = 1'b0;
            for (int i = 0; i < 4096; i++) begin
                if (res_valid) early++;
                step();
            end
            chk("wd_no_early", early, 0);
            chk("wd_res", {res_valid, res_err, res_digit}, {1'b1, 1'b1, 4'hF});
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            chk("wd_clear", {res_valid, res_err}, 0);
        end
`else
        chk("res_err_tied", res_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mnist_frame_feeder.md
Name: mnist_frame_feeder

Overview:
- Upstream stage of the handwriting recognizer.
- Accepts a 28x28 grayscale frame as 784 8-bit pixels over a valid/ready stream and binarizes each pixel against a threshold into a 784-bit frame buffer.
- Pulses the recognizer's active-high reset, then streams the 784 bits serially, one per clock, on consecutive cycles.
- Waits for the recognizer's result_valid, captures digit_out and presents it on a valid/ready result port.

Parameters:
- NPIX, 784, pixels per frame; also the serial stream length.
- THRESHOLD, 8'd128, binarization level; bit = (pixel >= THRESHOLD).
- RST_CYCLES, 2, number of cycles rec_rst is held high before streaming; minimum 1.
- TIMEOUT_CYCLES, 4096, recognizer watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  single clock for the block and the recognizer.
- rst  in  1  asynchronous, active-low reset.
- pix_data  in  8  grayscale pixel, row-major, pixel 0 = row 0 col 0.
- pix_valid  in  1  pix_data valid.
- pix_ready  out  1  block accepts a pixel when pix_valid && pix_ready.
- rec_rst  out  1  active-high reset to the recognizer.
- rec_data  out  1  serial bit to the recognizer's data_in.
- rec_busy  in  1  recognizer busy; status only.
- rec_digit  in  4  recognizer digit_out.
- rec_valid  in  1  recognizer result_valid.
- res_digit  out  4  captured digit, 0-9.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result when res_valid && res_ready.
- res_err  out  1  timeout flag; constant 0 without the optional feature.

Behaviour:
- Reset values (rst low, asynchronous): state LOAD, pix_ready=1, rec_rst=1, rec_data=0, res_digit=0, res_valid=0, res_err=0, pixel counter=0, frame buffer=0.
- Counter and buffer: pixel counter is 10 bits wide. The frame buffer is an NPIX-bit register.
- LOAD:
  - pix_ready=1; rec_rst=1 (recognizer held in reset).
  - Each handshake writes bit[cnt] = (pix_data >= THRESHOLD), using an unsigned compare, then increments cnt.
  - On the handshake with cnt==NPIX-1, pix_ready drops on the next cycle, cnt clears and the state goes to RST.
  - pix_valid without pix_ready has no effect. The stream may stall arbitrarily.
- RST:
  - rec_rst=1 for exactly RST_CYCLES cycles, counted from RST entry. Then rec_rst=0 and the state goes to SEND.
- SEND:
  - In the first cycle with rec_rst=0, rec_data=bit[0]. Cycle k after the rec_rst fall carries bit[k], k=0..NPIX-1, with no gaps.
  - After bit[NPIX-1] is driven, rec_data returns to 0 and the state goes to WAIT.
  - rec_data must be registered (glitch-free) and aligned so that the recognizer's first post-reset edge samples bit[0].
- WAIT:
  - On the first cycle with rec_valid=1, latch res_digit=rec_digit, set res_valid=1 and go to OUT.
  - rec_busy is ignored for control.
- OUT:
  - res_valid holds and res_digit is stable until res_valid && res_ready.
  - On that cycle: res_valid=0 next cycle, rec_rst=1, state LOAD, pix_ready=1 next cycle.
- Back-pressure: pixels are never accepted outside LOAD, so a new frame cannot overwrite the buffer during SEND/WAIT/OUT.
- Reset mid-operation: any state returns to reset values immediately. A partial frame is discarded. rec_rst asserts asynchronously.
- Digits outside 0-9 from the recognizer are passed through unchanged.

Optional Feature:
- Macro: MNIST_FEEDER_TIMEOUT_EN.
- Defined:
  - A 13-bit watchdog counts cycles in WAIT.
  - If TIMEOUT_CYCLES elapse without rec_valid, the block enters OUT with res_digit=4'hF, res_valid=1, res_err=1.
  - res_err clears together with res_valid on the consumer handshake.
  - A rec_valid arriving in the same cycle the watchdog expires wins, and res_err=0.
- Undefined: no watchdog logic; res_err tied to 0; WAIT waits indefinitely.

Test Plan:
1. Full frame with pixels alternating 8'd200/8'd10, pix_valid held high -> pix_ready low after the 784th handshake. rec_rst high for 2 cycles. rec_data then shows 1,0,1,0... for 784 consecutive cycles starting the cycle rec_rst falls.
2. Threshold boundary, pixels 127 and 128 at indices 0 and 1, rest 0 -> streamed bit0=0, bit1=1, rest 0.
3. Random pix_valid gaps (30% idle) -> identical rec_data sequence to the gap-free run; no pixel lost or duplicated; pix_valid during SEND is not accepted.
4. Recognizer model asserts rec_valid with rec_digit=7 100 cycles after the stream ends; res_ready held low 20 cycles then high -> res_valid=1 and res_digit=7 stable for 21 cycles. Next cycle res_valid=0, pix_ready=1, rec_rst=1.
5. rst pulled low at pixel 400, then a new full frame -> buffer restarts at index 0; only the new frame is streamed.
6. With MNIST_FEEDER_TIMEOUT_EN, rec_valid never asserted -> after 4096 WAIT cycles res_valid=1, res_digit=4'hF, res_err=1; both clear after the res_ready handshake.
